// File: rtl/rpn_pkg.sv
// Shared constants for the RPN sequencer: opcodes, error codes, FSM encoding
// and default sizing.
package rpn_pkg;

    localparam int DW_DEF    = 32;
    localparam int DEPTH_DEF = 16;
    localparam int CW_DEF    = 5;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_OUT = 3'd7;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_UNDER = 2'd1;
    localparam logic [1:0] ERR_OVER  = 2'd2;
    localparam logic [1:0] ERR_BADOP = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PUSH  = 3'd1,
        S_POP_B = 3'd2,
        S_POP_A = 3'd3,
        S_EXEC  = 3'd4,
        S_OUT   = 3'd5,
        S_ERROR = 3'd6
    } state_e;

endpackage

// File: rtl/rpn_alu.sv
// Combinational RPN ALU: result = A op B, where B was the top of stack.
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [2:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SHL:  result = a << b[4:0];
            OP_SHR:  result = a >> b[4:0];
            default: result = b;  // OUT never reaches the push path
        endcase
    end

endmodule

// File: rtl/rpn_sequencer.sv
// Token-driven RPN controller: drives the operand stack's push/pop handshakes,
// evaluates operators through rpn_alu and returns OUT results on RES_*.
module rpn_sequencer
    import rpn_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          TOK_VLD,
    output logic          TOK_RDY,
    input  logic          TOK_OP,
    input  logic [DW-1:0] TOK_DAT,
    output logic          STK_PUSH_STB,
    output logic [DW-1:0] STK_PUSH_DAT,
    input  logic          STK_PUSH_ACK,
    output logic          STK_POP_REQ,
    input  logic          STK_POP_ACK,
    input  logic [DW-1:0] STK_POP_DAT,
    output logic          RES_VLD,
    input  logic          RES_RDY,
    output logic [DW-1:0] RES_DAT,
    output logic          ERR,
    output logic [1:0]    ERR_CODE,
    output logic [CW-1:0] LEVEL,
    output logic [2:0]    DBG_STATE
);

    // Every handshake completes on a rising edge where the request side
    // (TOK_VLD, STK_PUSH_STB, STK_POP_REQ, RES_VLD) and its partner
    // (TOK_RDY, STK_PUSH_ACK, STK_POP_ACK, RES_RDY) are both high; a raised
    // request and its data stay unchanged until that edge.

    state_e        state_q, state_nxt;
    logic [CW-1:0] level_q;
    logic [DW-1:0] push_dat_q, a_q, b_q, alu_res;
    logic [2:0]    op_q;
    logic [1:0]    err_code_q, err_val;
    logic          err_set, live_q, tok_acc;

    assign tok_acc = TOK_VLD && TOK_RDY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= S_IDLE;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        err_set   = 1'b0;
        err_val   = ERR_NONE;
        case (state_q)
            S_IDLE: if (tok_acc) begin
                if (!TOK_OP) begin
                    if (level_q == CW'(DEPTH)) begin
                        state_nxt = S_ERROR; err_set = 1'b1; err_val = ERR_OVER;
                    end else begin
                        state_nxt = S_PUSH;
                    end
                end else if ((TOK_DAT[2:0] == OP_OUT) ? (level_q == '0) : (level_q < CW'(2))) begin
                    state_nxt = S_ERROR; err_set = 1'b1; err_val = ERR_UNDER;
                end else begin
                    state_nxt = S_POP_B;
                end
            end
            S_PUSH:  if (STK_PUSH_ACK) state_nxt = S_IDLE;
            S_POP_B: if (STK_POP_ACK)  state_nxt = (op_q == OP_OUT) ? S_OUT : S_POP_A;
            S_POP_A: if (STK_POP_ACK)  state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_PUSH;
            S_OUT:   if (RES_RDY)      state_nxt = S_IDLE;
            S_ERROR: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // live_q holds TOK_RDY low until the first clock after reset release.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            live_q     <= 1'b0;
            level_q    <= '0;
            push_dat_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_ADD;
            err_code_q <= ERR_NONE;
        end else begin
            live_q <= 1'b1;
            if (tok_acc && !TOK_OP) push_dat_q <= TOK_DAT;
            if (tok_acc &&  TOK_OP) op_q       <= TOK_DAT[2:0];
            if (err_set)            err_code_q <= err_val;
            case (state_q)
                S_PUSH:  if (STK_PUSH_ACK) level_q <= level_q + CW'(1);
                S_POP_B: if (STK_POP_ACK) begin
                    b_q     <= STK_POP_DAT;
                    level_q <= level_q - CW'(1);
                end
                S_POP_A: if (STK_POP_ACK) begin
                    a_q     <= STK_POP_DAT;
                    level_q <= level_q - CW'(1);
                end
                S_EXEC:  push_dat_q <= alu_res;
                default: ;
            endcase
        end
    end

    rpn_alu #(.DW(DW)) u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_res)
    );

    assign TOK_RDY      = (state_q == S_IDLE) && live_q;
    assign STK_PUSH_STB = (state_q == S_PUSH);
    assign STK_PUSH_DAT = push_dat_q;
    assign STK_POP_REQ  = (state_q == S_POP_B) || (state_q == S_POP_A);
    assign RES_VLD      = (state_q == S_OUT);
    assign RES_DAT      = b_q;
    assign ERR          = (state_q == S_ERROR);
    assign ERR_CODE     = err_code_q;
    assign LEVEL        = level_q;
    assign DBG_STATE    = state_q;

endmodule

// File: tb/tb_rpn_sequencer.sv
// Self-checking bench for rpn_sequencer: stack/result responder with
// programmable stalls, queue-based RPN reference model and directed/random tests.
module tb_rpn_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        TOK_VLD = 1'b0, TOK_OP = 1'b0;
    logic [31:0] TOK_DAT = '0;
    logic        TOK_RDY;
    logic        STK_PUSH_STB, STK_POP_REQ, RES_VLD, ERR;
    logic [31:0] STK_PUSH_DAT, RES_DAT;
    logic        STK_PUSH_ACK = 1'b0, STK_POP_ACK = 1'b0, RES_RDY = 1'b0;
    logic [31:0] STK_POP_DAT = '0;
    logic [1:0]  ERR_CODE;
    logic [4:0]  LEVEL;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    // reference model and scoreboard
    logic [31:0] ref_stk[$];
    logic [31:0] exp_q[$];
    logic [1:0]  err_q[$];

    // responder (the attached stack) state
    logic [31:0] stk_mem[$];
    int push_delay = 0, pop_delay = 0, res_delay = 0;

    rpn_sequencer dut (
        .CLK(CLK), .RST_N(RST_N),
        .TOK_VLD(TOK_VLD), .TOK_RDY(TOK_RDY), .TOK_OP(TOK_OP), .TOK_DAT(TOK_DAT),
        .STK_PUSH_STB(STK_PUSH_STB), .STK_PUSH_DAT(STK_PUSH_DAT), .STK_PUSH_ACK(STK_PUSH_ACK),
        .STK_POP_REQ(STK_POP_REQ), .STK_POP_ACK(STK_POP_ACK), .STK_POP_DAT(STK_POP_DAT),
        .RES_VLD(RES_VLD), .RES_RDY(RES_RDY), .RES_DAT(RES_DAT),
        .ERR(ERR), .ERR_CODE(ERR_CODE), .LEVEL(LEVEL), .DBG_STATE(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_alu(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int sh;
        longint unsigned prod;
        sh = int'(b % 32);
        case (o)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: begin prod = longint'(a) * (64'd1 << sh); return prod[31:0]; end
            default: return a / (32'd1 << sh);
        endcase
    endfunction

    function automatic void model_apply(input logic op, input logic [31:0] dat);
        logic [31:0] a, b;
        int need;
        if (!op) begin
            if (ref_stk.size() == 16) err_q.push_back(2'd2);
            else ref_stk.push_back(dat);
        end else begin
            need = (dat[2:0] == 3'd7) ? 1 : 2;
            if (ref_stk.size() < need) err_q.push_back(2'd1);
            else begin
                b = ref_stk.pop_back();
                if (dat[2:0] == 3'd7) exp_q.push_back(b);
                else begin
                    a = ref_stk.pop_back();
                    ref_stk.push_back(ref_alu(dat[2:0], a, b));
                end
            end
        end
    endfunction

    // ---------------- responder + monitor ----------------
    initial begin : env
        logic        pend_push, pend_pop, prev_push_wait, prev_res_wait, prev_err;
        logic [31:0] pend_dat, prev_push_dat, prev_res_dat;
        int          push_cnt, pop_cnt, res_cnt;
        logic [1:0]  e;
        logic [31:0] r;
        pend_push = 0; pend_pop = 0; prev_push_wait = 0; prev_res_wait = 0; prev_err = 0;
        pend_dat = '0; prev_push_dat = '0; prev_res_dat = '0;
        push_cnt = 0; pop_cnt = 0; res_cnt = 0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                stk_mem.delete();
                pend_push = 0; pend_pop = 0; prev_push_wait = 0; prev_res_wait = 0; prev_err = 0;
                push_cnt = 0; pop_cnt = 0; res_cnt = 0;
                STK_PUSH_ACK = 0; STK_POP_ACK = 0; RES_RDY = 0;
                continue;
            end
            if (pend_push) stk_mem.push_back(pend_dat);
            if (pend_pop && stk_mem.size() > 0) void'(stk_mem.pop_back());

            checks++;
            if (STK_PUSH_STB && STK_POP_REQ) begin
                errors++; $display("FAIL push_pop_excl: both high at %0t", $time);
            end
            if ((STK_PUSH_STB || STK_POP_REQ || RES_VLD || ERR) && TOK_RDY) begin
                errors++; $display("FAIL tok_rdy_busy: TOK_RDY=1 while busy at %0t", $time);
            end
            if (LEVEL > 5'd16) begin
                errors++; $display("FAIL level_range: LEVEL=%0d exceeds 16", LEVEL);
            end
            if (prev_push_wait) begin
                checks++;
                if (STK_PUSH_STB !== 1'b1 || STK_PUSH_DAT !== prev_push_dat) begin
                    errors++; $display("FAIL push_stable: stb=%b dat=%h required stb=1 dat=%h", STK_PUSH_STB, STK_PUSH_DAT, prev_push_dat);
                end
            end
            if (prev_res_wait) begin
                checks++;
                if (RES_VLD !== 1'b1 || RES_DAT !== prev_res_dat) begin
                    errors++; $display("FAIL res_stable: vld=%b dat=%h required vld=1 dat=%h", RES_VLD, RES_DAT, prev_res_dat);
                end
            end
            if (ERR) begin
                checks++;
                if (err_q.size() == 0) begin
                    errors++; $display("FAIL err_unexpected: ERR=1 code=%0d, no error required", ERR_CODE);
                end else begin
                    e = err_q.pop_front();
                    if (ERR_CODE !== e) begin
                        errors++; $display("FAIL err_code: got %0d required %0d", ERR_CODE, e);
                    end
                end
                if (prev_err) begin
                    errors++; $display("FAIL err_pulse: ERR high for more than one cycle");
                end
            end
            prev_err = ERR;

            if (STK_PUSH_STB) begin
                if (push_cnt < push_delay) begin STK_PUSH_ACK = 0; push_cnt++; end
                else begin STK_PUSH_ACK = 1; push_cnt = 0; end
            end else begin STK_PUSH_ACK = 0; push_cnt = 0; end
            pend_push = STK_PUSH_STB && STK_PUSH_ACK;
            pend_dat = STK_PUSH_DAT;
            prev_push_wait = STK_PUSH_STB && !STK_PUSH_ACK;
            prev_push_dat = STK_PUSH_DAT;

            if (STK_POP_REQ) begin
                if (pop_cnt < pop_delay) begin STK_POP_ACK = 0; pop_cnt++; end
                else begin STK_POP_ACK = 1; pop_cnt = 0; end
            end else begin STK_POP_ACK = 0; pop_cnt = 0; end
            STK_POP_DAT = (stk_mem.size() > 0) ? stk_mem[$] : $urandom;
            pend_pop = STK_POP_REQ && STK_POP_ACK;

            if (RES_VLD) begin
                if (res_cnt < res_delay) begin RES_RDY = 0; res_cnt++; end
                else begin RES_RDY = 1; res_cnt = 0; end
            end else begin RES_RDY = 0; res_cnt = 0; end
            prev_res_wait = RES_VLD && !RES_RDY;
            prev_res_dat = RES_DAT;
            if (RES_VLD && RES_RDY) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL res_unexpected: RES_DAT=%h with no result required", RES_DAT);
                end else begin
                    r = exp_q.pop_front();
                    if (RES_DAT !== r) begin
                        errors++; $display("FAIL res_dat: got %h required %h", RES_DAT, r);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_tok(input logic op, input logic [31:0] dat);
        int n;
        n = 0;
        @(negedge CLK);
        while (!TOK_RDY && n < 200) begin @(negedge CLK); n++; end
        if (!TOK_RDY) begin
            errors++; $display("FAIL tok_timeout: TOK_RDY never rose for op=%b dat=%h", op, dat);
            return;
        end
        TOK_VLD = 1'b1; TOK_OP = op; TOK_DAT = dat;
        @(posedge CLK);
        model_apply(op, dat);
        @(negedge CLK);
        TOK_VLD = 1'b0; TOK_OP = $urandom_range(0, 1); TOK_DAT = $urandom;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!TOK_RDY && n < 200) begin @(negedge CLK); n++; end
        checks++;
        if (!TOK_RDY || LEVEL !== 5'(ref_stk.size())) begin
            errors++; $display("FAIL %s_level: rdy=%b LEVEL=%0d required %0d", name, TOK_RDY, LEVEL, ref_stk.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if (TOK_RDY !== 0 || STK_PUSH_STB !== 0 || STK_POP_REQ !== 0 || RES_VLD !== 0 ||
            ERR !== 0 || ERR_CODE !== 2'd0 || LEVEL !== 5'd0 || RES_DAT !== 32'd0 || STK_PUSH_DAT !== 32'd0) begin
            errors++; $display("FAIL reset_outputs: rdy=%b stb=%b req=%b vld=%b err=%b code=%0d lvl=%0d required all 0",
                               TOK_RDY, STK_PUSH_STB, STK_POP_REQ, RES_VLD, ERR, ERR_CODE, LEVEL);
        end
        RST_N = 1'b1;
    endtask

    task automatic test_basic();
        int n;
        send_tok(1'b0, 32'd5);
        checks++;
        if (STK_PUSH_STB !== 1'b1 || STK_PUSH_DAT !== 32'd5) begin
            errors++; $display("FAIL basic_push: stb=%b dat=%h required stb=1 dat=5", STK_PUSH_STB, STK_PUSH_DAT);
        end
        send_tok(1'b0, 32'd3);
        send_tok(1'b1, 32'd0);
        n = 1;
        while (!TOK_RDY && n < 50) begin @(negedge CLK); n++; end
        checks++;
        if (n != 5) begin
            errors++; $display("FAIL basic_op_latency: %0d cycles required 5", n);
        end
        send_tok(1'b1, 32'd7);
        n = 1;
        while (!RES_VLD && n < 50) begin @(negedge CLK); n++; end
        checks++;
        if (n != 2 || RES_DAT !== 32'd8) begin
            errors++; $display("FAIL basic_out: vld after %0d dat=%h required 2 and 8", n, RES_DAT);
        end
        wait_idle("basic");
    endtask

    task automatic test_sub();
        send_tok(1'b0, 32'd10); send_tok(1'b0, 32'd4); send_tok(1'b1, 32'd1); send_tok(1'b1, 32'd7);
        wait_idle("sub1");
        send_tok(1'b0, 32'd4); send_tok(1'b0, 32'd10); send_tok(1'b1, 32'd1); send_tok(1'b1, 32'd7);
        @(negedge CLK);
        checks++;
        if (RES_VLD !== 1'b1 || RES_DAT !== 32'hFFFF_FFFA) begin
            errors++; $display("FAIL sub_wrap: vld=%b dat=%h required 1 and fffffffa", RES_VLD, RES_DAT);
        end
        wait_idle("sub2");
    endtask

    task automatic test_underflow();
        send_tok(1'b1, 32'd7);
        checks++;
        if (ERR !== 1'b1 || ERR_CODE !== 2'd1 || STK_POP_REQ !== 1'b0) begin
            errors++; $display("FAIL under_out: err=%b code=%0d req=%b required 1,1,0", ERR, ERR_CODE, STK_POP_REQ);
        end
        @(negedge CLK);
        checks++;
        if (ERR !== 1'b0 || STK_POP_REQ !== 1'b0 || ERR_CODE !== 2'd1) begin
            errors++; $display("FAIL under_pulse: err=%b req=%b code=%0d required 0,0,1", ERR, STK_POP_REQ, ERR_CODE);
        end
        send_tok(1'b0, 32'd7);
        send_tok(1'b1, 32'd0);
        checks++;
        if (ERR !== 1'b1 || ERR_CODE !== 2'd1 || STK_POP_REQ !== 1'b0) begin
            errors++; $display("FAIL under_add: err=%b code=%0d req=%b required 1,1,0", ERR, ERR_CODE, STK_POP_REQ);
        end
        wait_idle("under");
        send_tok(1'b1, 32'd7);
        wait_idle("under_drain");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 17; i++) send_tok(1'b0, 32'(i * 3 + 1));
        checks++;
        if (STK_PUSH_STB !== 1'b0 || ERR !== 1'b1 || ERR_CODE !== 2'd2) begin
            errors++; $display("FAIL over_17th: stb=%b err=%b code=%0d required 0,1,2", STK_PUSH_STB, ERR, ERR_CODE);
        end
        wait_idle("over");
        for (int i = 0; i < 16; i++) send_tok(1'b1, 32'd7);
        wait_idle("over_drain");
    endtask

    task automatic test_stall();
        int n;
        push_delay = 3; res_delay = 2;
        send_tok(1'b0, 32'h1234_5678);
        n = 0;
        while (STK_PUSH_STB && n < 20) begin n++; @(negedge CLK); end
        checks++;
        if (n != 4) begin
            errors++; $display("FAIL stall_push: STB high %0d cycles required 4", n);
        end
        send_tok(1'b1, 32'd7);
        @(negedge CLK);
        n = 0;
        while (RES_VLD && n < 20) begin n++; @(negedge CLK); end
        checks++;
        if (n != 3) begin
            errors++; $display("FAIL stall_res: RES_VLD high %0d cycles required 3", n);
        end
        wait_idle("stall");
        push_delay = 0; res_delay = 0;
    endtask

    task automatic test_random();
        logic [31:0] d;
        for (int i = 0; i < 300; i++) begin
            push_delay = $urandom_range(0, 2);
            pop_delay  = $urandom_range(0, 2);
            res_delay  = $urandom_range(0, 2);
            d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if ($urandom_range(0, 99) < 50) send_tok(1'b0, d);
            else send_tok(1'b1, 32'($urandom_range(0, 7)));
            if (i % 25 == 0) wait_idle("rand");
        end
        while (ref_stk.size() > 0) send_tok(1'b1, 32'd7);
        wait_idle("rand_drain");
        push_delay = 0; pop_delay = 0; res_delay = 0;
    endtask

    task automatic test_reset_mid();
        send_tok(1'b0, 32'd6); send_tok(1'b0, 32'd7); send_tok(1'b1, 32'd0);
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if (STK_POP_REQ !== 0 || STK_PUSH_STB !== 0 || RES_VLD !== 0 || ERR !== 0 ||
            TOK_RDY !== 0 || LEVEL !== 5'd0 || ERR_CODE !== 2'd0) begin
            errors++; $display("FAIL reset_mid: req=%b stb=%b vld=%b err=%b rdy=%b lvl=%0d code=%0d required all 0",
                               STK_POP_REQ, STK_PUSH_STB, RES_VLD, ERR, TOK_RDY, LEVEL, ERR_CODE);
        end
        ref_stk.delete(); exp_q.delete(); err_q.delete();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        send_tok(1'b0, 32'd11);
        wait_idle("reset_mid_push");
        send_tok(1'b1, 32'd7);
        wait_idle("reset_mid_out");
    endtask

    task automatic test_end();
        repeat (3) @(negedge CLK);
        checks++;
        if (exp_q.size() != 0 || err_q.size() != 0 || stk_mem.size() != ref_stk.size()) begin
            errors++; $display("FAIL end_queues: results=%0d errs=%0d stack=%0d left, required 0,0,%0d",
                               exp_q.size(), err_q.size(), stk_mem.size(), ref_stk.size());
        end
    endtask

    initial begin : main
        test_reset();
        test_basic();
        test_sub();
        test_underflow();
        test_overflow();
        test_stall();
        test_random();
        test_reset_mid();
        test_end();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
